// File: rtl/uart_rx_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_if
//   Bundle of the receive-side UART signals. It carries the serial line in,
//   the per-bit strobe out to the SIPO, and the word handshake towards the
//   host-side consumer.
//
//   Signals:
//     rx         serial line into the controller (idles high)
//     shift_en   one-cycle strobe per received data bit
//     shift_bit  sampled data bit, valid while shift_en = 1
//     rx_data    received word, bit 0 = first data bit on the line
//     rx_valid   rx_data holds an unconsumed word
//     rx_ready   consumer accepts the word
//     frame_err  one-cycle pulse: stop bit sampled low
//     overrun    one-cycle pulse: good frame dropped, previous word unread
//     busy       receiver is in the middle of a frame
//
//   Modports:
//     master  receiver side (drives strobes, word and flags)
//     slave   pin / SIPO / consumer side
// ----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx;
  logic                 shift_en;
  logic                 shift_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx,
    input  rx_ready,
    output shift_en,
    output shift_bit,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output rx_ready,
    input  shift_en,
    input  shift_bit,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side UART controller. Synchronises the raw rx line, qualifies
//   the start bit at mid-bit, samples each data bit at its centre, strobes
//   every data bit out to the SIPO, assembles the word in a shadow register,
//   checks the stop bit and hands the finished word to the consumer through
//   a valid/ready handshake with frame-error and overrun pulses.
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//     DATA_BITS     data bits per frame, LSB first (5..9)
//
//   Ports:
//     clk    system clock, all state moves on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    uart_rx_ctrl_if.master (rx, rx_ready in; strobes, word, flags out)
//
//   All outputs are registered.
// ----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.master bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_ZERO      = {BW{1'b0}};
  localparam logic [BW-1:0] IDX_ONE       = BW'(1);
  localparam logic [BW-1:0] IDX_LAST      = BW'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] WORD_ZERO = {DATA_BITS{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchroniser stages; both idle high so reset never looks like a start bit.
  logic rx_meta_r;
  logic rx_s;

  state_t               state_r,     state_n;
  logic [CW-1:0]        cnt_r,       cnt_n;
  logic [BW-1:0]        idx_r,       idx_n;
  logic [DATA_BITS-1:0] shadow_r,    shadow_n;
  logic                 shift_en_r,  shift_en_n;
  logic                 shift_bit_r, shift_bit_n;
  logic [DATA_BITS-1:0] rx_data_r,   rx_data_n;
  logic                 rx_valid_r,  rx_valid_n;
  logic                 frame_err_r, frame_err_n;
  logic                 overrun_r,   overrun_n;
  logic                 busy_r,      busy_n;
  logic                 stop_good_s;
  logic                 load_s;

  // Two-flop synchroniser on the asynchronous rx pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_s      <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, bit timing, shadow assembly and word delivery.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r + CNT_ONE;
    idx_n       = idx_r;
    shadow_n    = shadow_r;
    shift_en_n  = 1'b0;
    shift_bit_n = 1'b0;
    frame_err_n = 1'b0;
    stop_good_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        cnt_n = CNT_ZERO;
        idx_n = IDX_ZERO;
        if (!rx_s) begin
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_START: begin
        // Half a bit in: a line already back high was only a glitch.
        if (cnt_r == CNT_HALF_LAST) begin
          cnt_n = CNT_ZERO;
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = S_START;
        end
      end

      S_DATA: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_n           = CNT_ZERO;
          shift_en_n      = 1'b1;
          shift_bit_n     = rx_s;
          shadow_n[idx_r] = rx_s;
          if (idx_r == IDX_LAST) begin
            idx_n   = IDX_ZERO;
            state_n = S_STOP;
          end else begin
            idx_n   = idx_r + IDX_ONE;
            state_n = S_DATA;
          end
        end else begin
          state_n = S_DATA;
        end
      end

      S_STOP: begin
        // Leaving at mid-stop lets a directly following start bit be caught.
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_n = CNT_ZERO;
          if (rx_s) begin
            stop_good_s = 1'b1;
            state_n     = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            shadow_n    = WORD_ZERO;
            state_n     = S_BREAK;
          end
        end else begin
          state_n = S_STOP;
        end
      end

      S_BREAK: begin
        // A line held low must return high before a new start is accepted.
        cnt_n = CNT_ZERO;
        if (rx_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_BREAK;
        end
      end

      default: begin
        cnt_n   = CNT_ZERO;
        idx_n   = IDX_ZERO;
        state_n = S_IDLE;
      end
    endcase

    // A good frame loads when the slot is free or is being emptied this edge.
    load_s    = stop_good_s && (!rx_valid_r || bus.rx_ready);
    overrun_n = stop_good_s && rx_valid_r && !bus.rx_ready;

    if (load_s) begin
      rx_valid_n = 1'b1;
      rx_data_n  = shadow_r;
    end else if (rx_valid_r && bus.rx_ready) begin
      rx_valid_n = 1'b0;
      rx_data_n  = rx_data_r;
    end else begin
      rx_valid_n = rx_valid_r;
      rx_data_n  = rx_data_r;
    end

    busy_n = (state_n != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= CNT_ZERO;
      idx_r       <= IDX_ZERO;
      shadow_r    <= WORD_ZERO;
      shift_en_r  <= 1'b0;
      shift_bit_r <= 1'b0;
      rx_data_r   <= WORD_ZERO;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      shadow_r    <= shadow_n;
      shift_en_r  <= shift_en_n;
      shift_bit_r <= shift_bit_n;
      rx_data_r   <= rx_data_n;
      rx_valid_r  <= rx_valid_n;
      frame_err_r <= frame_err_n;
      overrun_r   <= overrun_n;
      busy_r      <= busy_n;
    end
  end

  assign bus.shift_en  = shift_en_r;
  assign bus.shift_bit = shift_bit_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed plus random-byte bench for uart_rx_ctrl (CLKS_PER_BIT = 16,
//   DATA_BITS = 8). Inputs change 1 time unit after the falling edge, and
//   everything is observed 3-4 units after the falling edge, well away from
//   the rising edge. Expected values come from a frame-level model: a word
//   slot with valid/data, a list of consumed words, expected strobe bits and
//   pulse counts.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int FRAME_CYC = 10 * CPB;
  localparam int STOP_C = 154;  // line cycle whose following edge is the stop sample

  logic clk = 1'b0;
  logic rst_n;
  logic rx_drv;
  logic rdy;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();
  assign bus.rx       = rx_drv;
  assign bus.rx_ready = rdy;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Monitor-side observations.
  int         cyc      = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         vhi_cnt  = 0;
  int         fid      = 0;
  logic       act_bits[$];
  int         act_cyc[$];
  int         act_fid[$];
  logic [7:0] act_acc[$];

  // Reference model.
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_acc[$];
  int         m_ferr;
  int         m_ovr;
  logic       m_bits[$];
  int         last_start;

  // Observe outputs mid-low-phase; handshake recorded when it will happen at the next edge.
  always @(negedge clk) begin
    #3;
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.shift_en) begin
        act_bits.push_back(bus.shift_bit);
        act_cyc.push_back(cyc + 1);
        act_fid.push_back(fid);
      end
      if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
      if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
      if (bus.rx_valid)  vhi_cnt  <= vhi_cnt + 1;
      if (bus.rx_valid && rdy) act_acc.push_back(bus.rx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] d, input logic stopb, input int c);
    int k;
    k = c / CPB;
    if (k == 0)      return 1'b0;
    else if (k <= 8) return d[k-1];
    else             return stopb;
  endfunction

  task automatic model_hs(input logic r);
    if (m_valid && r) begin
      m_acc.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  // One full 10-bit frame; r is rx_ready for the frame, r_stop its value on the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic r, input logic r_stop);
    logic old;
    fid = fid + 1;
    last_start = cyc + 1;
    model_hs(r);
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk); #1;
      rx_drv = line_bit(d, stopb, c);
      rdy    = (c == STOP_C) ? r_stop : r;
    end
    #3;
    for (int i = 0; i < DB; i++) m_bits.push_back(d[i]);
    old = m_valid;
    if (stopb) begin
      if (old && r_stop) m_acc.push_back(m_data);
      if (!old || r_stop) begin
        m_data  = d;
        m_valid = 1'b1;
      end else begin
        m_ovr++;
      end
    end else begin
      model_hs(r_stop);
      m_ferr++;
    end
    model_hs(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      rx_drv = 1'b1;
    end
    #3;
    model_hs(rdy);
  endtask

  task automatic chk_word(input string tag);
    chk({tag, "_valid"}, 32'(bus.rx_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(bus.rx_data),  32'(m_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a5_fid, a5_start, vhi0, first;
    logic [7:0] rd;
    logic rr;

    rst_n = 1'b0; rx_drv = 1'b1; rdy = 1'b0;
    m_valid = 1'b0; m_data = 8'h00; m_ferr = 0; m_ovr = 0; last_start = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    #4;
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_valid",     32'(bus.rx_valid),  32'd0);
    chk("rst_data",      32'(bus.rx_data),   32'd0);
    chk("rst_shift_en",  32'(bus.shift_en),  32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_overrun",   32'(bus.overrun),   32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // 0xA5 with consumer always ready.
    vhi0 = vhi_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    a5_fid = fid; a5_start = last_start;
    chk_word("a5");
    chk("a5_busy_low",    32'(bus.busy), 32'd0);
    chk("a5_valid_cycles", 32'(vhi_cnt - vhi0), 32'd1);
    chk("a5_ferr", 32'(ferr_cnt), 32'(m_ferr));
    idle(3);

    // Start glitch: 4 low cycles, then high.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      rx_drv = (c < 4) ? 1'b0 : 1'b1;
      #3;
      if (c == 10) chk("glitch_busy_hi", 32'(bus.busy), 32'd1);
      if (c == 11) chk("glitch_busy_lo", 32'(bus.busy), 32'd0);
    end
    chk("glitch_no_strobe", 32'(act_bits.size()), 32'(m_bits.size()));
    chk_word("glitch");
    idle(2);

    // 0x3C with a low stop bit, line kept low, then 0x81.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("brk_ferr", 32'(ferr_cnt), 32'(m_ferr));
    chk_word("brk");
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      rx_drv = 1'b0;
      #3;
      if (k == 39) chk("brk_busy_held", 32'(bus.busy), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      rx_drv = 1'b1;
      #3;
      if (k == 2) chk("brk_busy_exit_hi", 32'(bus.busy), 32'd1);
      if (k == 3) chk("brk_busy_exit_lo", 32'(bus.busy), 32'd0);
    end
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    chk_word("after_brk");
    idle(2);

    // Overrun: consumer not ready for 0x11 then 0x22.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk_word("ovr_first");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk_word("ovr_second");
    chk("ovr_pulses", 32'(ovr_cnt), 32'(m_ovr));
    @(negedge clk); #1;
    rdy = 1'b1;
    #3;
    chk("ovr_valid_before_edge", 32'(bus.rx_valid), 32'(m_valid));
    model_hs(1'b1);
    @(negedge clk); #1;
    rdy = 1'b0;
    #3;
    chk("ovr_valid_cleared", 32'(bus.rx_valid), 32'(m_valid));
    idle(2);

    // Ready raised exactly on the stop-sample edge of the second word.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    chk_word("same_edge");
    chk("same_edge_no_ovr", 32'(ovr_cnt), 32'(m_ovr));

    // Reset in the middle of data bit 4 of 0xC3; 0x22 is still held.
    fid = fid + 1;
    for (int c = 0; c < 85; c++) begin
      @(negedge clk); #1;
      rx_drv = line_bit(8'hC3, 1'b1, c);
    end
    for (int i = 0; i < 4; i++) m_bits.push_back(rd_bit(8'hC3, i));
    m_valid = 1'b0;
    m_data  = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      rst_n  = 1'b0;
      rx_drv = (k < 3) ? 1'b0 : 1'b1;
      #3;
      chk("in_reset_outputs",
          32'({bus.shift_en, bus.shift_bit, bus.rx_valid, bus.frame_err,
               bus.overrun, bus.busy, bus.rx_data}), 32'd0);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    chk_word("post_rst");

    // Random bytes, back-to-back, random consumer readiness per frame.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rr = 1'($urandom_range(0, 1));
      send_frame(rd, 1'b1, rr, rr);
      chk_word("rand");
    end
    rdy = 1'b1;
    idle(3);
    chk_word("drain");

    // Frame-level comparisons against the model.
    chk("strobe_count", 32'(act_bits.size()), 32'(m_bits.size()));
    for (int i = 0; i < act_bits.size() && i < m_bits.size(); i++)
      chk("strobe_bit", 32'(act_bits[i]), 32'(m_bits[i]));
    for (int i = 1; i < act_cyc.size(); i++)
      if (act_fid[i] == act_fid[i-1])
        chk("strobe_spacing", 32'(act_cyc[i] - act_cyc[i-1]), 32'(CPB));
    first = -1;
    for (int i = 0; i < act_fid.size(); i++)
      if (first < 0 && act_fid[i] == a5_fid) first = i;
    chk("a5_first_strobe_found", 32'(first >= 0), 32'd1);
    if (first >= 0)
      chk("a5_first_strobe_time", 32'(act_cyc[first] - a5_start), 32'(3 + CPB/2 + CPB));
    chk("accepted_count", 32'(act_acc.size()), 32'(m_acc.size()));
    for (int i = 0; i < act_acc.size() && i < m_acc.size(); i++)
      chk("accepted_word", 32'(act_acc[i]), 32'(m_acc[i]));
    chk("total_frame_err", 32'(ferr_cnt), 32'(m_ferr));
    chk("total_overrun",   32'(ovr_cnt),  32'(m_ovr));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] d, input int i);
    return d[i];
  endfunction

endmodule
